// File: rtl/aes_pkg.sv
// Shared definitions for the AES PRNG reseed scheduler.
// Contents:
//   prng_reseed_rate_e   - one-hot reseed rate encodings
//   Reload*              - block-counter reload values per rate
//   reseed_sched_state_e - sparse FSM state encodings
//   rate_valid()         - legality check for the rate input
//   reload_for()         - reload value for a (legal) rate
package aes_pkg;

    typedef enum logic [2:0] {
        PER_1  = 3'b001,
        PER_64 = 3'b010,
        PER_8K = 3'b100
    } prng_reseed_rate_e;

    localparam int unsigned ReloadPer1  = 0;
    localparam int unsigned ReloadPer64 = 63;
    localparam int unsigned ReloadPer8k = 8191;

    // Pairwise Hamming distance >= 3: a single bit flip never lands on another
    // valid state and is caught by the default branch, which goes to StError.
    typedef enum logic [5:0] {
        StIdle       = 6'b101101,
        StReseedClr  = 6'b000111,
        StReseedMask = 6'b111000,
        StDone       = 6'b011011,
        StError      = 6'b000000
    } reseed_sched_state_e;

    function automatic logic rate_valid(input logic [2:0] rate);
        return (rate == PER_1) || (rate == PER_64) || (rate == PER_8K);
    endfunction

    // Illegal rates map to the largest reload; they force StError anyway.
    function automatic int unsigned reload_for(input logic [2:0] rate);
        case (rate)
            PER_1:   return ReloadPer1;
            PER_64:  return ReloadPer64;
            default: return ReloadPer8k;
        endcase
    endfunction

endpackage

// File: rtl/aes_reseed_blk_ctr.sv
// Block down-counter for automatic reseeding.
// Ports:
//   clk_i      - clock
//   rst_ni     - synchronous active-low reset, clears the count
//   en         - counter may change (low freezes it)
//   load       - load reload_val (wins over dec)
//   reload_val - value loaded when a reseed sequence starts
//   dec        - one completed block; decrements unless already zero
//   is_zero    - count is zero
module aes_reseed_blk_ctr #(
    parameter int unsigned BlkCntWidth = 13
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   en,
    input  logic                   load,
    input  logic [BlkCntWidth-1:0] reload_val,
    input  logic                   dec,
    output logic                   is_zero
);

    logic [BlkCntWidth-1:0] cnt;

    assign is_zero = (cnt == '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (en) begin
            if (load) begin
                cnt <= reload_val;
            end else if (dec && !is_zero) begin
                cnt <= cnt - BlkCntWidth'(1);
            end
        end
    end

endmodule

// File: rtl/aes_prng_reseed_sched.sv
// Reseed scheduler for the AES clearing and masking PRNGs. Reseeds share one
// entropy path, so the clearing PRNG is reseeded first and the masking PRNG
// (if present) afterwards. Triggers: software, key write, or block count.
// Ports:
//   prng_reseed_rate_i - one-hot rate (PER_1 / PER_64 / PER_8K), others fatal
//   block_done_i       - pulse per completed cipher block
//   sw_reseed_i        - software reseed trigger
//   key_touch_i        - qualified key write trigger
//   clr_reseed_req_o / clr_reseed_ack_i   - clearing PRNG reseed handshake
//   mask_reseed_req_o / mask_reseed_ack_i - masking PRNG reseed handshake
//   stall_o            - blocks the control FSM from starting a block
//   busy_o             - reseed sequence in progress
//   reseed_done_o      - pulse at the end of a sequence
//   sw_reseed_clr_o    - clears the software trigger bit when a sequence starts
//   alert_o            - fatal alert, sticky until reset
module aes_prng_reseed_sched
    import aes_pkg::*;
#(
    parameter bit          SecMasking  = 1'b0,
    parameter int unsigned BlkCntWidth = 13
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [2:0] prng_reseed_rate_i,
    input  logic       block_done_i,
    input  logic       sw_reseed_i,
    input  logic       key_touch_i,
    output logic       clr_reseed_req_o,
    input  logic       clr_reseed_ack_i,
    output logic       mask_reseed_req_o,
    input  logic       mask_reseed_ack_i,
    output logic       stall_o,
    output logic       busy_o,
    output logic       reseed_done_o,
    output logic       sw_reseed_clr_o,
    output logic       alert_o
);

    reseed_sched_state_e state, state_next;

    logic                   pending;
    logic                   auto_pending;
    logic                   sw_clr;
    logic                   err;
    logic                   trig;
    logic                   start;
    logic                   run;
    logic                   cnt_zero;
    logic [BlkCntWidth-1:0] reload_val;

    assign run        = (state != StError);
    assign reload_val = BlkCntWidth'(reload_for(prng_reseed_rate_i));

    // An ack is only legal on the channel whose request is currently up.
    assign err = !rate_valid(prng_reseed_rate_i) ||
                 (clr_reseed_ack_i && (state != StReseedClr)) ||
                 (mask_reseed_ack_i && (!SecMasking || (state != StReseedMask)));

    assign trig  = sw_reseed_i || key_touch_i || pending || auto_pending;
    assign start = (state == StIdle) && trig && !err;

    aes_reseed_blk_ctr #(
        .BlkCntWidth(BlkCntWidth)
    ) u_blk_ctr (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .en        (run),
        .load      (start),
        .reload_val(reload_val),
        .dec       (block_done_i),
        .is_zero   (cnt_zero)
    );

    // Trigger merging: everything collapses into one request until the next start.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pending      <= 1'b0;
            auto_pending <= 1'b0;
            sw_clr       <= 1'b0;
        end else begin
            sw_clr <= start;
            if (start) begin
                pending      <= 1'b0;
                auto_pending <= 1'b0;
            end else if (run) begin
                if (sw_reseed_i || key_touch_i) begin
                    pending <= 1'b1;
                end
                if (block_done_i && cnt_zero) begin
                    auto_pending <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= StIdle;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            StIdle: begin
                if (trig) begin
                    state_next = StReseedClr;
                end
            end
            StReseedClr: begin
                if (clr_reseed_ack_i) begin
                    state_next = SecMasking ? StReseedMask : StDone;
                end
            end
            StReseedMask: begin
                if (mask_reseed_ack_i) begin
                    state_next = StDone;
                end
            end
            StDone:  state_next = StIdle;
            StError: state_next = StError;
            default: state_next = StError;
        endcase
        if (err) begin
            state_next = StError;
        end
    end

    always_comb begin
        clr_reseed_req_o  = 1'b0;
        mask_reseed_req_o = 1'b0;
        busy_o            = 1'b0;
        reseed_done_o     = 1'b0;
        alert_o           = 1'b0;
        case (state)
            StIdle: ;
            StReseedClr: begin
                clr_reseed_req_o = 1'b1;
                busy_o           = 1'b1;
            end
            StReseedMask: begin
                mask_reseed_req_o = 1'b1;
                busy_o            = 1'b1;
            end
            StDone: begin
                reseed_done_o = 1'b1;
                busy_o        = 1'b1;
            end
            default: alert_o = 1'b1;
        endcase
        stall_o = busy_o || auto_pending || alert_o;
    end

    assign sw_reseed_clr_o = sw_clr;

endmodule

// File: tb/tb_aes_prng_reseed_sched.sv
// Bench for aes_prng_reseed_sched: one instance with masking, one without,
// both checked every cycle against a block-counting reference model.
module tb_aes_prng_reseed_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] rate;
    logic       block_done, sw_reseed, key_touch;
    logic       clr_ack [2];
    logic       mask_ack [2];
    logic       clr_req [2];
    logic       mask_req [2];
    logic       stall [2];
    logic       busy [2];
    logic       done [2];
    logic       swclr [2];
    logic       alert [2];

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    bit auto_ack [2];
    int n_done [2];
    int n_swclr [2];
    bit mask1_seen = 1'b0;

    // Reference model: 0 idle, 1 clr, 2 mask, 3 done, 4 error.
    int m_st [2];
    int m_seen [2];
    int m_limit [2];
    bit m_pend [2];
    bit m_apend [2];
    bit m_swclr [2];

    always #5 clk = ~clk;

    aes_prng_reseed_sched #(.SecMasking(1'b1), .BlkCntWidth(13)) u_dut_mask (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .prng_reseed_rate_i(rate),
        .block_done_i      (block_done),
        .sw_reseed_i       (sw_reseed),
        .key_touch_i       (key_touch),
        .clr_reseed_req_o  (clr_req[0]),
        .clr_reseed_ack_i  (clr_ack[0]),
        .mask_reseed_req_o (mask_req[0]),
        .mask_reseed_ack_i (mask_ack[0]),
        .stall_o           (stall[0]),
        .busy_o            (busy[0]),
        .reseed_done_o     (done[0]),
        .sw_reseed_clr_o   (swclr[0]),
        .alert_o           (alert[0])
    );

    aes_prng_reseed_sched #(.SecMasking(1'b0), .BlkCntWidth(13)) u_dut_nomask (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .prng_reseed_rate_i(rate),
        .block_done_i      (block_done),
        .sw_reseed_i       (sw_reseed),
        .key_touch_i       (key_touch),
        .clr_reseed_req_o  (clr_req[1]),
        .clr_reseed_ack_i  (clr_ack[1]),
        .mask_reseed_req_o (mask_req[1]),
        .mask_reseed_ack_i (mask_ack[1]),
        .stall_o           (stall[1]),
        .busy_o            (busy[1]),
        .reseed_done_o     (done[1]),
        .sw_reseed_clr_o   (swclr[1]),
        .alert_o           (alert[1])
    );

    function automatic int reload_of(input logic [2:0] r);
        if (r == 3'b001) return 0;
        if (r == 3'b010) return 63;
        return 8191;
    endfunction

    // Auto reseed fires on the first block after 'limit' blocks since the last start.
    task automatic step(input int i);
        bit legal, bad, trig, start;
        if (!rst_n) begin
            m_st[i] = 0; m_seen[i] = 0; m_limit[i] = 0;
            m_pend[i] = 0; m_apend[i] = 0; m_swclr[i] = 0;
        end else if (m_st[i] == 4) begin
            m_swclr[i] = 0;
        end else begin
            legal = (rate == 3'b001) || (rate == 3'b010) || (rate == 3'b100);
            bad = !legal || (clr_ack[i] && m_st[i] != 1) ||
                  (mask_ack[i] && (m_st[i] != 2 || i == 1));
            trig = sw_reseed || key_touch || m_pend[i] || m_apend[i];
            start = (m_st[i] == 0) && trig && !bad;
            m_swclr[i] = start;
            if (start) begin
                m_limit[i] = reload_of(rate);
                m_seen[i] = 0; m_pend[i] = 0; m_apend[i] = 0;
            end else begin
                if (block_done) begin
                    if (m_seen[i] >= m_limit[i]) m_apend[i] = 1;
                    else m_seen[i]++;
                end
                if (sw_reseed || key_touch) m_pend[i] = 1;
            end
            if (bad) m_st[i] = 4;
            else if (m_st[i] == 0 && start) m_st[i] = 1;
            else if (m_st[i] == 1 && clr_ack[i]) m_st[i] = (i == 0) ? 2 : 3;
            else if (m_st[i] == 2 && mask_ack[i]) m_st[i] = 3;
            else if (m_st[i] == 3) m_st[i] = 0;
        end
    endtask

    // Bit order: {clr_req, mask_req, stall, busy, done, sw_clr, alert}
    function automatic logic [6:0] exp_vec(input int i);
        logic c, m, d, a, b, s;
        c = (m_st[i] == 1); m = (m_st[i] == 2); d = (m_st[i] == 3); a = (m_st[i] == 4);
        b = c | m | d;
        s = b | m_apend[i] | a;
        return {c, m, s, b, d, m_swclr[i], a};
    endfunction

    function automatic logic [6:0] dut_vec(input int i);
        return {clr_req[i], mask_req[i], stall[i], busy[i], done[i], swclr[i], alert[i]};
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) step(i);
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            if (auto_ack[i]) begin
                clr_ack[i]  = (m_st[i] == 1) && ($urandom_range(0, 2) == 0);
                mask_ack[i] = (m_st[i] == 2) && ($urandom_range(0, 2) == 0);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dut_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL model_cmp[%0d] t=%0t: got %b want %b (clr,mask,stall,busy,done,swclr,alert)",
                             i, $time, dut_vec(i), exp_vec(i));
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (done[i] === 1'b1) n_done[i]++;
            if (swclr[i] === 1'b1) n_swclr[i]++;
        end
        if (mask_req[1] === 1'b1) mask1_seen = 1'b1;
    end

    task automatic check_vec(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    function automatic bit all_idle();
        return m_st[0] == 0 && m_st[1] == 0 && !m_pend[0] && !m_pend[1] &&
               !m_apend[0] && !m_apend[1];
    endfunction

    task automatic wait_idle(input string name, input int bound);
        int n;
        n = 0;
        while (!all_idle() && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (!all_idle()) begin
            errors++;
            $display("FAIL %s: still busy after %0d cycles, got st=%0d/%0d want idle",
                     name, bound, m_st[0], m_st[1]);
        end
    endtask

    task automatic set_manual0();
        auto_ack[0] = 1'b0;
        clr_ack[0]  = 1'b0;
        mask_ack[0] = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] v;
        int r;
        rst_n = 1'b0; rate = 3'b010; block_done = 1'b0; sw_reseed = 1'b0; key_touch = 1'b0;
        clr_ack[0] = 1'b0; clr_ack[1] = 1'b0; mask_ack[0] = 1'b0; mask_ack[1] = 1'b0;
        auto_ack[0] = 1'b0; auto_ack[1] = 1'b1;
        n_done[0] = 0; n_done[1] = 0; n_swclr[0] = 0; n_swclr[1] = 0;
        tick();
        cmp_en = 1'b1;
        tick();
        check_vec("reset_outputs_mask", dut_vec(0), 7'b0);
        check_vec("reset_outputs_nomask", dut_vec(1), 7'b0);
        check_vec("model_reset", exp_vec(0), 7'b0);
        rst_n = 1'b1;
        tick();

        // First block with counter at zero: stall next cycle, request the cycle after.
        block_done = 1'b1; tick(); block_done = 1'b0;
        check_vec("t1_stall_only", dut_vec(0), 7'b0010000);
        v = exp_vec(0);
        check_vec("model_t1_stall_only", v, 7'b0010000);
        tick();
        check_vec("t1_clr_req_swclr", dut_vec(0), 7'b1011010);
        ticks(2);
        check_vec("t1_clr_req_held", dut_vec(0), 7'b1011000);
        clr_ack[0] = 1'b1; tick(); clr_ack[0] = 1'b0;
        check_vec("t1_mask_req", dut_vec(0), 7'b0111000);
        tick();
        mask_ack[0] = 1'b1; tick(); mask_ack[0] = 1'b0;
        check_vec("t1_done_pulse", dut_vec(0), 7'b0011100);
        tick();
        check_vec("t1_back_idle", dut_vec(0), 7'b0);
        v = exp_vec(0);
        check_vec("model_t1_back_idle", v, 7'b0);
        wait_idle("t1_idle", 200);

        // PER_64: 63 blocks quiet, the 64th triggers.
        block_done = 1'b1; ticks(63); block_done = 1'b0; tick();
        check_vec("t2_63_blocks_quiet", dut_vec(0), 7'b0);
        check_vec("t2_63_blocks_quiet_nm", dut_vec(1), 7'b0);
        block_done = 1'b1; tick(); block_done = 1'b0;
        check_vec("t2_64th_stall", dut_vec(0), 7'b0010000);
        tick();
        check_vec("t2_64th_req", dut_vec(0), 7'b1011010);
        auto_ack[0] = 1'b1;
        wait_idle("t2_idle", 200);

        // PER_8K: reload via software, then 8191 quiet blocks and one more.
        rate = 3'b100;
        sw_reseed = 1'b1; tick(); sw_reseed = 1'b0;
        wait_idle("t2b_idle", 200);
        block_done = 1'b1; ticks(8191); block_done = 1'b0; tick();
        check_vec("t2c_8191_quiet", dut_vec(0), 7'b0);
        block_done = 1'b1; tick(); block_done = 1'b0;
        check_vec("t2c_8192nd_stall", dut_vec(0), 7'b0010000);
        check_vec("t2c_8192nd_stall_nm", dut_vec(1), 7'b0010000);
        wait_idle("t2c_idle", 200);

        // Merged triggers: two sequences in total.
        rate = 3'b010;
        ticks(2);
        n_done[0] = 0; n_done[1] = 0; n_swclr[0] = 0; n_swclr[1] = 0;
        sw_reseed = 1'b1; key_touch = 1'b1; tick(); sw_reseed = 1'b0; key_touch = 1'b0;
        check_vec("t3_latency1_mask", dut_vec(0) & 7'b1000010, 7'b1000010);
        check_vec("t3_latency1_nomask", dut_vec(1) & 7'b1000010, 7'b1000010);
        tick();
        sw_reseed = 1'b1; tick(); sw_reseed = 1'b0;
        wait_idle("t3_idle", 300);
        ticks(5);
        check_int("t3_done_count_mask", n_done[0], 2);
        check_int("t3_swclr_count_mask", n_swclr[0], 2);
        check_int("t3_done_count_nomask", n_done[1], 2);
        check_int("t3_swclr_count_nomask", n_swclr[1], 2);

        // Illegal rate: both alert, triggers ignored, reset clears.
        rate = 3'b011; tick(); rate = 3'b010;
        check_vec("t5_bad_rate_mask", dut_vec(0), 7'b0010001);
        check_vec("t5_bad_rate_nomask", dut_vec(1), 7'b0010001);
        sw_reseed = 1'b1; tick(); sw_reseed = 1'b0; tick();
        check_vec("t5_sticky_alert", dut_vec(0), 7'b0010001);
        rst_n = 1'b0; tick();
        check_vec("t5_reset_clears", dut_vec(0), 7'b0);
        check_vec("t5_reset_clears_nm", dut_vec(1), 7'b0);
        rst_n = 1'b1; tick();

        // Mask ack while the clearing request is up.
        set_manual0();
        sw_reseed = 1'b1; tick(); sw_reseed = 1'b0;
        check_vec("t5b_clr_req", dut_vec(0) & 7'b1000000, 7'b1000000);
        mask_ack[0] = 1'b1; tick(); mask_ack[0] = 1'b0;
        check_vec("t5b_alert", dut_vec(0), 7'b0010001);
        check_vec("t5b_other_ok", dut_vec(1) & 7'b0000001, 7'b0);
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();

        // Reset while a request is outstanding.
        sw_reseed = 1'b1; tick(); sw_reseed = 1'b0;
        check_vec("t6_req_up", dut_vec(0), 7'b1011010);
        rst_n = 1'b0; tick();
        check_vec("t6_req_dropped", dut_vec(0), 7'b0);
        rst_n = 1'b1; tick();
        check_vec("t6_no_done", dut_vec(0), 7'b0);
        block_done = 1'b1; tick(); block_done = 1'b0;
        check_vec("t6_cnt_was_zero", dut_vec(0), 7'b0010000);
        auto_ack[0] = 1'b1;
        wait_idle("t6_idle", 200);

        // Randomised traffic with legal rates.
        for (int k = 0; k < 4000; k++) begin
            block_done = ($urandom_range(0, 2) == 0);
            sw_reseed  = ($urandom_range(0, 39) == 0);
            key_touch  = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 199) == 0) begin
                r = $urandom_range(0, 9);
                rate = (r < 5) ? 3'b001 : ((r < 9) ? 3'b010 : 3'b100);
            end
            tick();
        end
        block_done = 1'b0; sw_reseed = 1'b0; key_touch = 1'b0;
        wait_idle("rand_idle", 300);
        ticks(3);
        check_int("nomask_never_mask_req", int'(mask1_seen), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_prng_reseed_sched.md
Name: aes_prng_reseed_sched

Overview:
Schedules reseeding of the two AES-internal PRNGs: the clearing PRNG owned by the control path, and the masking PRNG owned by the cipher core. Both share one entropy (EDN) path, so the two reseeds are always serialised, never concurrent. A reseed is triggered by software, by a key write when key-touch reseed is enabled, or automatically every N processed blocks according to the reseed rate. The block sits beside the AES control FSM and gates block starts through stall_o.

Parameters:
SecMasking, 0, 1 = masking PRNG present; reseed it after the clearing PRNG. 0 = skip the RESEED_MASK state.
BlkCntWidth, 13, width of the block-down-counter; must hold 8191.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
prng_reseed_rate_i  in  3  reseed rate: 3'b001 PER_1, 3'b010 PER_64, 3'b100 PER_8K; any other value is invalid
block_done_i  in  1  one-cycle pulse per completed cipher block
sw_reseed_i  in  1  software reseed trigger pulse
key_touch_i  in  1  key register write pulse, already qualified by key_touch_forces_reseed
clr_reseed_req_o  out  1  clearing PRNG reseed request
clr_reseed_ack_i  in  1  clearing PRNG reseed acknowledge (one-cycle pulse)
mask_reseed_req_o  out  1  masking PRNG reseed request
mask_reseed_ack_i  in  1  masking PRNG reseed acknowledge (one-cycle pulse)
stall_o  out  1  1 = control FSM must not start a new block
busy_o  out  1  reseed sequence in progress
reseed_done_o  out  1  one-cycle pulse when a sequence completes
sw_reseed_clr_o  out  1  clears the software trigger register bit
alert_o  out  1  fatal alert; sticky until reset

Behaviour:
- Reset (rst_ni=0 sampled at a clk_i edge): state IDLE, blk_cnt=0, pending=0, auto_pending=0. All outputs are 0.
- States: IDLE, RESEED_CLR, RESEED_MASK, DONE, ERROR.
- Reload value R by rate: PER_1 → 0, PER_64 → 63, PER_8K → 8191.
- Counter:
  - A block_done_i pulse with blk_cnt>0 decrements blk_cnt.
  - A block_done_i pulse with blk_cnt==0 sets auto_pending; blk_cnt holds at 0.
  - The counter keeps counting in every state except ERROR.
- Triggers: sw_reseed_i, key_touch_i and auto_pending are OR-merged into one pending request.
  - Any number of simultaneous or repeated triggers before a sequence starts yields exactly one sequence.
- IDLE with pending=1 → RESEED_CLR on the next edge. On that same edge:
  - blk_cnt ← R for the current rate;
  - pending and auto_pending are cleared;
  - sw_reseed_clr_o pulses for 1 cycle.
- A trigger in cycle t, with the FSM in IDLE, gives clr_reseed_req_o=1 in cycle t+1 (all outputs are registered state decodes). Minimum latency is 1 cycle.
- Triggers arriving while busy set pending. A second sequence starts from IDLE after the current one finishes.
- RESEED_CLR: clr_reseed_req_o=1, held until clr_reseed_ack_i.
  - ack in cycle a → cycle a+1 is RESEED_MASK if SecMasking=1, else DONE.
- RESEED_MASK: mask_reseed_req_o=1, held until mask_reseed_ack_i. ack in cycle b → DONE in cycle b+1.
- DONE: reseed_done_o=1 for 1 cycle, then IDLE.
- busy_o=1 in RESEED_CLR, RESEED_MASK and DONE.
- stall_o = busy_o | auto_pending.
  - sw_reseed and key_touch triggers do not stall while the FSM is still in IDLE.
  - In PER_1 mode, every block is therefore followed by a full reseed before the next block starts.
- ERROR, terminal until reset: alert_o=1, stall_o=1, both reqs=0, reseed_done_o=0. Entered on the next edge when any of these holds:
  - prng_reseed_rate_i is not one of the three legal codes, in any state;
  - clr_reseed_ack_i=1 outside RESEED_CLR;
  - mask_reseed_ack_i=1 outside RESEED_MASK (always an error if SecMasking=0).
- Reset mid-sequence: the request drops on the reset edge and no done pulse is produced. The PRNGs must tolerate an abandoned request.
- Acks on both channels in the same cycle are always an error, because only one request is ever outstanding.

Decomposition:
- Shared package aes_pkg:
  - prng_reseed_rate_e (PER_1/PER_64/PER_8K encodings);
  - reload constants;
  - reseed_sched_state_e with sparse (Hamming distance ≥3) encodings, so that a single upset decodes to ERROR.
- One natural sub-module: aes_reseed_blk_ctr, the down-counter with load/decrement/zero-detect, taking BlkCntWidth and the reload value.
- The FSM stays in the top module.

Test Plan:
- Reset, then rate=PER_64, SecMasking=1, one block_done_i pulse (blk_cnt starts at 0) → stall_o=1 next cycle; clr_req=1 one cycle later. Ack clr after 3 cycles → mask_req=1. Ack mask → reseed_done_o pulse; blk_cnt=63; stall_o=0.
- PER_64 after reload, 63 block_done pulses → no request. 64th pulse → auto_pending=1 and a sequence starts. PER_8K: 8191 pulses quiet, 8192nd triggers.
- sw_reseed_i and key_touch_i in the same cycle, plus sw_reseed_i again 2 cycles later while busy → first sequence completes, then exactly one further sequence. sw_reseed_clr_o pulses once per sequence start.
- SecMasking=0, sw_reseed_i → clr_req, ack → DONE. mask_reseed_req_o is never 1.
- rate=3'b011, or mask_ack while in RESEED_CLR → alert_o=1 next cycle; reqs=0. Further triggers are ignored until rst_ni=0, after which all outputs are 0.
- rst_ni=0 while clr_req=1 → req=0 after the edge; no reseed_done_o; blk_cnt=0.
